// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter with 9-region address decode and timeout.
// Latency: unmapped access acks 1 cycle after grant; mapped acks 1 cycle after peripheral ack.
// Backpressure: one transfer in flight; requesters hold req until their ack pulse.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_m0_* / o_m0_*          instruction-fetch master (req/addr/we/wdata/wstrb, ack/rdata/err)
//   i_m1_* / o_m1_*          data master, same set
//   o_sel                    one-hot region select (valid only while waiting on a peripheral)
//   o_addr/o_we/o_wdata/o_wstrb  latched transfer fields, driven only while waiting
//   i_ack, i_rdata           per-region completion and read data (region n at [32n+31:32n])
module bus_arbiter #(
  parameter logic [31:0] BOOT_SIZE = 32'h0000_2000,
  parameter int          XV6_EN    = 0,
  parameter int          TIMEOUT   = 256
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_m0_req,
  input  logic [31:0]  i_m0_addr,
  input  logic         i_m0_we,
  input  logic [31:0]  i_m0_wdata,
  input  logic [3:0]   i_m0_wstrb,
  output logic         o_m0_ack,
  output logic [31:0]  o_m0_rdata,
  output logic         o_m0_err,
  input  logic         i_m1_req,
  input  logic [31:0]  i_m1_addr,
  input  logic         i_m1_we,
  input  logic [31:0]  i_m1_wdata,
  input  logic [3:0]   i_m1_wstrb,
  output logic         o_m1_ack,
  output logic [31:0]  o_m1_rdata,
  output logic         o_m1_err,
  output logic [8:0]   o_sel,
  output logic [31:0]  o_addr,
  output logic         o_we,
  output logic [31:0]  o_wdata,
  output logic [3:0]   o_wstrb,
  input  logic [8:0]   i_ack,
  input  logic [287:0] i_rdata
);

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        state_q, state_d;
  logic          last_m1_q;   // last grant went to M1
  logic          gnt_m1_q;    // master owning the current transfer
  logic [8:0]    sel_q;
  logic [31:0]   addr_q, wdata_q, rdata_q;
  logic          we_q, err_q;
  logic [3:0]    wstrb_q;
  logic [CW-1:0] cnt_q;

  logic          any_req, grant_m1;
  logic [31:0]   req_addr, req_wdata;
  logic          req_we;
  logic [3:0]    req_wstrb;
  logic [8:0]    dec_sel;
  logic          dec_hit;
  logic          ack_hit, timeout_hit;
  logic [31:0]   sel_rdata;

  // Round robin: on a tie the master that was not served last wins.
  assign any_req   = i_m0_req | i_m1_req;
  assign grant_m1  = i_m1_req & (~i_m0_req | ~last_m1_q);
  assign req_addr  = grant_m1 ? i_m1_addr  : i_m0_addr;
  assign req_we    = grant_m1 ? i_m1_we    : i_m0_we;
  assign req_wdata = grant_m1 ? i_m1_wdata : i_m0_wdata;
  assign req_wstrb = grant_m1 ? i_m1_wstrb : i_m0_wstrb;

  // Boot region takes priority over the nibble decode; an empty dec_sel means unmapped.
  always_comb begin
    dec_sel = '0;
    dec_hit = 1'b0;
    if (req_addr < BOOT_SIZE) begin
      dec_sel = 9'h001;
      dec_hit = 1'b1;
    end else if (req_addr[31:28] >= 4'h1 && req_addr[31:28] <= 4'h7) begin
      dec_sel = 9'(1) << req_addr[31:28];
      dec_hit = 1'b1;
    end else if (req_addr[31:28] == 4'h8 && XV6_EN != 0) begin
      dec_sel = 9'h100;
      dec_hit = 1'b1;
    end
  end

  always_comb begin
    sel_rdata = '0;
    for (int n = 0; n < 9; n++) begin
      if (sel_q[n]) sel_rdata = sel_rdata | i_rdata[32*n +: 32];
    end
  end

  // Only the selected region's ack counts; it beats a simultaneous timeout.
  assign ack_hit     = |(i_ack & sel_q);
  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (any_req) state_d = dec_hit ? S_WAIT : S_RESP;
      S_WAIT:  if (ack_hit || timeout_hit) state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      last_m1_q <= 1'b1;
      gnt_m1_q  <= 1'b0;
      sel_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (any_req) begin
            last_m1_q <= grant_m1;
            gnt_m1_q  <= grant_m1;
            addr_q    <= req_addr;
            we_q      <= req_we;
            wdata_q   <= req_wdata;
            wstrb_q   <= req_wstrb;
            sel_q     <= dec_sel;
            err_q     <= ~dec_hit;
            rdata_q   <= dec_hit ? 32'h0 : ERR_DATA;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (ack_hit) begin
            rdata_q <= we_q ? 32'h0 : sel_rdata;
            err_q   <= 1'b0;
          end else if (timeout_hit) begin
            rdata_q <= ERR_DATA;
            err_q   <= 1'b1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  always_comb begin
    o_sel   = '0;
    o_addr  = '0;
    o_we    = 1'b0;
    o_wdata = '0;
    o_wstrb = '0;
    if (state_q == S_WAIT) begin
      o_sel   = sel_q;
      o_addr  = addr_q;
      o_we    = we_q;
      o_wdata = wdata_q;
      o_wstrb = wstrb_q;
    end
  end

  assign o_m0_ack   = (state_q == S_RESP) & ~gnt_m1_q;
  assign o_m1_ack   = (state_q == S_RESP) &  gnt_m1_q;
  assign o_m0_rdata = o_m0_ack ? rdata_q : 32'h0;
  assign o_m1_rdata = o_m1_ack ? rdata_q : 32'h0;
  assign o_m0_err   = o_m0_ack & err_q;
  assign o_m1_err   = o_m1_ack & err_q;

endmodule
